// File: rtl/shift_normalizer.sv
// shift_normalizer
//   Iterative leading/trailing-zero normalizer. A captured word is walked
//   through SHW binary-search stages (largest first), one stage per clock,
//   shifting out zero groups and accumulating the shift amount.
//   dir=0: left-normalize (MSB=1), o_shamt = leading zeros.
//   dir=1: right-normalize (LSB=1), o_shamt = trailing zeros.
//   All-zero input reports o_zero=1 with o_data=0, o_shamt=0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_valid/i_ready     input handshake; i_data word, i_dir direction
//   o_valid/o_ready     output handshake
//   o_data, o_shamt     normalized word and shift amount
//   o_zero, o_dir       zero-input flag, captured direction
//   o_ops_count         (only with NORM_PERF_EN) saturating count of
//                       output handshakes
//
// Optional feature macro: NORM_PERF_EN
module shift_normalizer #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_dir,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [SHW-1:0]   o_shamt,
  output logic             o_zero,
  output logic             o_dir
`ifdef NORM_PERF_EN
  ,
  output logic [15:0]      o_ops_count
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [WIDTH-1:0] ONES = '1;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_work, r_odata;
  logic [SHW-1:0]   r_count, r_k, r_oshamt;
  logic             r_dir, r_zero, r_ozero, r_odir;

  logic             w_accept, w_out_hs, w_hit;
  logic [SHW-1:0]   w_s, w_count_nx;
  logic [WIDTH-1:0] w_mask_hi, w_mask_lo, w_work_nx;

  assign w_accept = i_valid && i_ready;
  assign w_out_hs = o_valid && o_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_next = BUSY;
      BUSY:    if (r_k == '0)   w_next = DONE;
      DONE:    if (o_ready)     w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    i_ready = (r_state == IDLE);
    o_valid = (r_state == DONE);
  end

  // Current stage: group of s = 2^k bits at the end being normalized toward.
  // s <= WIDTH/2, so it fits in SHW bits.
  assign w_s       = SHW'(1) << r_k;
  assign w_mask_hi = ~(ONES >> w_s);
  assign w_mask_lo = ~(ONES << w_s);
  assign w_hit     = r_dir ? ((r_work & w_mask_lo) == '0)
                           : ((r_work & w_mask_hi) == '0);
  assign w_work_nx = !w_hit ? r_work : (r_dir ? (r_work >> w_s) : (r_work << w_s));
  assign w_count_nx = w_hit ? (r_count + w_s) : r_count;

  // Datapath. Output registers load only on the final stage so intermediate
  // work values never reach the ports and outputs hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work   <= '0;
      r_count  <= '0;
      r_k      <= '0;
      r_dir    <= 1'b0;
      r_zero   <= 1'b0;
      r_odata  <= '0;
      r_oshamt <= '0;
      r_ozero  <= 1'b0;
      r_odir   <= 1'b0;
    end else if (w_accept) begin
      r_work  <= i_data;
      r_dir   <= i_dir;
      r_zero  <= (i_data == '0);
      r_count <= '0;
      r_k     <= SHW'(SHW-1);
    end else if (r_state == BUSY) begin
      r_work  <= w_work_nx;
      r_count <= w_count_nx;
      r_k     <= r_k - 1'b1;
      if (r_k == '0) begin
        // An all-zero word would report a raw count of WIDTH-1; force 0.
        r_odata  <= r_zero ? '0 : w_work_nx;
        r_oshamt <= r_zero ? '0 : w_count_nx;
        r_ozero  <= r_zero;
        r_odir   <= r_dir;
      end
    end
  end

  assign o_data  = r_odata;
  assign o_shamt = r_oshamt;
  assign o_zero  = r_ozero;
  assign o_dir   = r_odir;

`ifdef NORM_PERF_EN
  logic [15:0] r_ops;
  always_ff @(posedge clk) begin
    if (rst)                           r_ops <= '0;
    else if (w_out_hs && r_ops != '1)  r_ops <= r_ops + 16'd1;
  end
  assign o_ops_count = r_ops;
`else
  logic w_unused;
  assign w_unused = w_out_hs;
`endif

endmodule

// File: tb/tb_shift_normalizer.sv
module tb_shift_normalizer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid, i_ready, i_dir, o_valid, o_ready, o_zero, o_dir;
  logic [W-1:0] i_data, o_data;
  logic [2:0]   o_shamt;
`ifdef NORM_PERF_EN
  logic [15:0]  o_ops_count;
`endif

  int compared   = 0;
  int mismatched = 0;
  int handshakes = 0;

  always #5 clk = ~clk;

  shift_normalizer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_dir(i_dir),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_shamt(o_shamt),
    .o_zero(o_zero), .o_dir(o_dir)
`ifdef NORM_PERF_EN
    , .o_ops_count(o_ops_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word, accept it, and wait (bounded) for o_valid.
  // lat = number of rising edges after the accept edge until o_valid.
  task automatic send(input logic [7:0] d, input logic dir, output int lat);
    int t = 0;
    while (!i_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) chk("i_ready_timeout", 32'(i_ready), 1);
    i_data = d; i_dir = dir; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_data  = ~d;              // post-accept changes must be ignored
    i_dir   = ~dir;
    lat = 0;
    while (!o_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (lat >= 20) chk("o_valid_timeout", 32'(o_valid), 1);
  endtask

  task automatic release_out();
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    handshakes++;
  endtask

  function automatic int ref_cnt(input logic [7:0] d, input logic dir);
    int n = 0;
    if (d == 0) return 0;
    if (!dir) begin for (int b = 7; b >= 0 && !d[b]; b--) n++; end
    else      begin for (int b = 0; b <= 7 && !d[b]; b++) n++; end
    return n;
  endfunction

  initial begin
    int lat;
    logic [7:0] hold_d;
    logic [7:0] rt;
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_dir = 1'b0; o_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_i_ready", 32'(i_ready), 1);
    chk("rst_o_valid", 32'(o_valid), 0);
    chk("rst_o_data",  32'(o_data),  0);
    chk("rst_o_shamt", 32'(o_shamt), 0);
    chk("rst_o_zero",  32'(o_zero),  0);
    chk("rst_o_dir",   32'(o_dir),   0);

    // Basic left
    send(8'h13, 1'b0, lat);
    chk("t1_latency", 32'(lat), 3);
    chk("t1_i_ready", 32'(i_ready), 0);
    chk("t1_data",  32'(o_data),  32'h98);
    chk("t1_shamt", 32'(o_shamt), 3);
    chk("t1_zero",  32'(o_zero),  0);
    chk("t1_dir",   32'(o_dir),   0);
    release_out();
    chk("t1_post_valid", 32'(o_valid), 0);
    chk("t1_post_ready", 32'(i_ready), 1);

    // Basic right
    send(8'h68, 1'b1, lat);
    chk("t2_latency", 32'(lat), 3);
    chk("t2_data",  32'(o_data),  32'h0D);
    chk("t2_shamt", 32'(o_shamt), 3);
    chk("t2_dir",   32'(o_dir),   1);
    release_out();

    // Boundaries
    send(8'h80, 1'b0, lat);
    chk("b_l80_data", 32'(o_data), 32'h80); chk("b_l80_shamt", 32'(o_shamt), 0);
    release_out();
    send(8'h01, 1'b0, lat);
    chk("b_l01_data", 32'(o_data), 32'h80); chk("b_l01_shamt", 32'(o_shamt), 7);
    release_out();
    send(8'h80, 1'b1, lat);
    chk("b_r80_data", 32'(o_data), 32'h01); chk("b_r80_shamt", 32'(o_shamt), 7);
    release_out();
    send(8'h00, 1'b0, lat);
    chk("b_l00_lat", 32'(lat), 3);
    chk("b_l00_zero", 32'(o_zero), 1); chk("b_l00_data", 32'(o_data), 0);
    chk("b_l00_shamt", 32'(o_shamt), 0);
    release_out();
    send(8'h00, 1'b1, lat);
    chk("b_r00_zero", 32'(o_zero), 1); chk("b_r00_data", 32'(o_data), 0);
    chk("b_r00_shamt", 32'(o_shamt), 0); chk("b_r00_dir", 32'(o_dir), 1);
    release_out();

    // Backpressure: 0x24 left -> 0x90, shamt 2
    send(8'h24, 1'b0, lat);
    hold_d = o_data;
    chk("bp_data_first", 32'(hold_d), 32'h90);
    for (int c = 0; c < 5; c++) begin
      chk("bp_o_valid", 32'(o_valid), 1);
      chk("bp_i_ready", 32'(i_ready), 0);
      chk("bp_data",    32'(o_data),  32'h90);
      chk("bp_shamt",   32'(o_shamt), 2);
      @(posedge clk); #1;
    end
    release_out();
    chk("bp_post_valid", 32'(o_valid), 0);
    chk("bp_post_ready", 32'(i_ready), 1);

    // Mid-operation reset one cycle after accept
    i_data = 8'h0C; i_dir = 1'b1; i_valid = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mr_o_valid", 32'(o_valid), 0);
    chk("mr_i_ready", 32'(i_ready), 1);
    chk("mr_o_data",  32'(o_data),  0);
    chk("mr_o_shamt", 32'(o_shamt), 0);
    chk("mr_o_zero",  32'(o_zero),  0);
    chk("mr_o_dir",   32'(o_dir),   0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("mr_no_partial", 32'(o_valid), 0);
    end
    handshakes = 0;            // perf counter restarts from reset
    send(8'h0C, 1'b1, lat);
    chk("mr_new_lat",   32'(lat), 3);
    chk("mr_new_data",  32'(o_data),  32'h03);
    chk("mr_new_shamt", 32'(o_shamt), 2);
    release_out();

    // Exhaustive sweep, random output stall
    for (int dir = 0; dir < 2; dir++) begin
      for (int v = 0; v < 256; v++) begin
        send(8'(v), 1'(dir), lat);
        chk("sw_lat",   32'(lat),     3);
        chk("sw_shamt", 32'(o_shamt), 32'(ref_cnt(8'(v), 1'(dir))));
        chk("sw_zero",  32'(o_zero),  32'(v == 0));
        rt = dir ? (o_data << o_shamt) : (o_data >> o_shamt);
        chk("sw_roundtrip", 32'(rt), 32'(v));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        release_out();
      end
    end
`ifdef NORM_PERF_EN
    chk("perf_ops_count", 32'(o_ops_count), 32'(handshakes));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
